// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: round-robin right-of-way owner for highway, country road and pedestrian phases
// Requests latch into pend and are served in order p+1, p+2 under green/yellow/all-red cycle timers.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int WALK_T    = 6,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 6
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [2:0] req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic       ped_flash,
    output logic [2:0] grant
);
    localparam logic [1:0] GRN = 2'd0, YEL = 2'd1, ARED = 2'd2;
    localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

    logic [1:0]       st_q, st_d, p_q, p_d, nxt_q, nxt_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       p_oh, others;
    logic [1:0]       p_inc1, p_inc2, nxt_pick;
    logic             req_p, green_done, enter_grn;

    always_comb begin
        p_oh       = 3'b001 << p_q;
        others     = pend_q & ~p_oh;
        req_p      = |(req & p_oh);
        p_inc1     = (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
        p_inc2     = (p_q == 2'd0) ? 2'd2 : p_q - 2'd1;
        nxt_pick   = pend_q[p_inc1] ? p_inc1 : pend_q[p_inc2] ? p_inc2 : 2'd0;
        green_done = (p_q == 2'd2) ? (tmr_q == WALK_LAST)
                   : (others != 3'b000) && ((tmr_q >= GMIN_LAST && !req_p) || tmr_q >= GMAX_LAST);
        enter_grn  = (st_q == ARED) && (tmr_q == AR_LAST);
        st_d       = st_q;
        p_d        = p_q;
        nxt_d      = nxt_q;
        tmr_d      = tmr_q + 1'b1;
        if (st_q == GRN) begin
            if (green_done) begin
                st_d  = YEL;
                nxt_d = nxt_pick;
                tmr_d = '0;
            end else if (p_q != 2'd2 && tmr_q == GMAX_LAST) begin
                tmr_d = tmr_q;
            end
        end else if (st_q == YEL) begin
            if (tmr_q == YEL_LAST) begin
                st_d  = ARED;
                tmr_d = '0;
            end
        end else if (tmr_q == AR_LAST || st_q != ARED) begin
            st_d  = GRN;
            p_d   = nxt_q;
            tmr_d = '0;
        end
        // a request for the phase already green is dropped; entering green clears its own bit
        pend_d = (pend_q | (req & ~((st_q == GRN) ? p_oh : 3'b000)))
               & ~(enter_grn ? (3'b001 << nxt_q) : 3'b000);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            st_q   <= GRN;
            p_q    <= 2'd0;
            nxt_q  <= 2'd0;
            tmr_q  <= '0;
            pend_q <= 3'b000;
        end else begin
            st_q   <= st_d;
            p_q    <= p_d;
            nxt_q  <= nxt_d;
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        hwy       = (st_q == GRN && p_q == 2'd0) ? GREEN : (st_q == YEL && p_q == 2'd0) ? YELLOW : RED;
        cntry     = (st_q == GRN && p_q == 2'd1) ? GREEN : (st_q == YEL && p_q == 2'd1) ? YELLOW : RED;
        walk      = (st_q == GRN) && (p_q == 2'd2);
        ped_flash = (st_q == YEL) && (p_q == 2'd2);
        grant     = p_oh;
    end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed phase-length checks plus randomized requests against a cycle model
// The model tracks stage, phase, age in stage and a waiting set, checked every cycle on the falling edge.
module tb_traffic_phase_scheduler;
    localparam int GREEN_MIN = 8, GREEN_MAX = 32, WALK_T = 6, YELLOW_T = 3, ALLRED_T = 2, CNT_W = 6;
    localparam logic [5:0] HG = 6'b100000, HY = 6'b010000, AR = 6'b000000;
    localparam logic [5:0] CG = 6'b001000, CY = 6'b000100, WK = 6'b000010, FL = 6'b000001;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [1:0] hwy, cntry;
    logic       walk, ped_flash;
    logic [2:0] grant;

    int vectors = 0, miscompares = 0;
    int m_stage = 0, m_ph = 0, m_tgt = 0, m_age = 0;
    bit [2:0] m_want = 3'b000;

    traffic_phase_scheduler #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .WALK_T(WALK_T),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .clear_n(clear_n), .req(req), .hwy(hwy), .cntry(cntry),
        .walk(walk), .ped_flash(ped_flash), .grant(grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] road(input int r);
        return (m_stage == 0 && m_ph == r) ? 2'd2 : (m_stage == 1 && m_ph == r) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [8:0] model_out();
        return {road(0), road(1), m_stage == 0 && m_ph == 2, m_stage == 1 && m_ph == 2, 3'(1 << m_ph)};
    endfunction

    task automatic model_step();
        bit [2:0] others;
        int nst, nph, nage, ntgt, k;
        bit leave, enter;
        nst = m_stage; nph = m_ph; ntgt = m_tgt; nage = m_age + 1; enter = 0;
        others = m_want;
        others[m_ph] = 1'b0;
        if (m_stage == 0) begin
            if (m_ph == 2) leave = (m_age + 1 == WALK_T);
            else leave = (others != 0) && ((m_age + 1 >= GREEN_MIN && !req[m_ph]) || m_age + 1 >= GREEN_MAX);
            if (leave) begin
                nst = 1; nage = 0; ntgt = 0;
                for (k = 2; k >= 1; k--) if (m_want[(m_ph + k) % 3]) ntgt = (m_ph + k) % 3;
            end else if (m_ph != 2 && nage > GREEN_MAX - 1) nage = GREEN_MAX - 1;
        end else if (m_stage == 1) begin
            if (m_age + 1 == YELLOW_T) begin nst = 2; nage = 0; end
        end else if (m_age + 1 == ALLRED_T) begin
            nst = 0; nph = m_tgt; nage = 0; enter = 1;
        end
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !(m_stage == 0 && m_ph == i)) m_want[i] = 1'b1;
            if (enter && nph == i) m_want[i] = 1'b0;
        end
        m_stage = nst; m_ph = nph; m_age = nage; m_tgt = ntgt;
    endtask

    initial forever begin
        @(posedge clock or negedge clear_n);
        if (!clear_n) begin
            m_stage = 0; m_ph = 0; m_tgt = 0; m_age = 0; m_want = 3'b000;
        end else model_step();
    end

    initial forever begin
        @(negedge clock);
        check("cycle", {hwy, cntry, walk, ped_flash, grant}, model_out());
    end

    task automatic count_run(input logic [5:0] v, input int limit, output int n);
        n = 0;
        while ({hwy, cntry, walk, ped_flash} == v && n < limit) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic pulse_at(input int delay, input logic [2:0] r);
        repeat (delay) @(negedge clock);
        req = r;
        @(negedge clock);
        req = 3'b000;
    endtask

    task automatic reset_check(input string name);
        #2 clear_n = 1'b0;
        #1 check(name, {hwy, cntry, walk, ped_flash, grant}, {HG, 3'b001});
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic run_table(input string name, input logic [5:0] pat[], input int len[]);
        int n;
        foreach (pat[i]) begin
            count_run(pat[i], 60, n);
            check($sformatf("%s_seg%0d", name, i), n, len[i]);
        end
    endtask

    initial begin
        int n;
        bit s0, s1;
        repeat (3) @(negedge clock);
        check("reset_out", {hwy, cntry, walk, ped_flash, grant}, {HG, 3'b001});
        clear_n = 1'b1;
        count_run(HG, 100, n);
        check("idle_hold", n, 100);
        check("idle_grant", grant, 3'b001);

        reset_check("async_idle");
        fork
            count_run(HG, 60, n);
            pulse_at(2, 3'b010);
        join
        check("hwy_min_green", n, 8);
        run_table("to_cntry", '{HY, AR}, '{3, 2});
        check("cntry_grant", grant, 3'b010);
        req = 3'b011;
        fork
            count_run(CG, 60, n);
            begin @(negedge clock); req = 3'b010; end
        join
        check("cntry_max_green", n, 32);
        req = 3'b000;
        run_table("to_hwy", '{CY, AR}, '{3, 2});
        check("hwy_back", {hwy, grant}, {2'd2, 3'b001});

        reset_check("async_before_ped");
        fork
            count_run(HG, 60, n);
            pulse_at(2, 3'b110);
        join
        check("hwy_green_d", n, 8);
        run_table("rotation", '{HY, AR, CG, CY, AR, WK, FL, AR}, '{3, 2, 8, 3, 2, 6, 3, 2});
        check("after_ped", {hwy, grant}, {2'd2, 3'b001});

        reset_check("async_before_e");
        fork
            count_run(HG, 60, n);
            pulse_at(2, 3'b100);
        join
        check("hwy_green_e", n, 8);
        run_table("to_walk", '{HY, AR}, '{3, 2});
        fork
            count_run(WK, 60, n);
            pulse_at(0, 3'b100);
        join
        check("walk_len", n, 6);
        fork
            count_run(FL, 60, n);
            pulse_at(0, 3'b010);
        join
        check("flash_len", n, 3);
        run_table("ped_to_cntry", '{AR, HG, HY, AR}, '{2, 8, 3, 2});
        count_run(CG, 40, n);
        check("cntry_hold_no_rereq", n, 40);
        check("cntry_hold_grant", grant, 3'b010);
        reset_check("async_mid_cntry");

        count_run(HG, 200, n);
        check("saturate_hold", n, 200);
        fork
            count_run(HG, 60, n);
            pulse_at(0, 3'b010);
        join
        check("saturated_exit", n, 2);

        s0 = 0; s1 = 0;
        for (int e = 0; e < 6; e++) begin
            for (int c = 0; c < 500; c++) begin
                @(negedge clock);
                if ($urandom_range(0, 4 + e * 8) == 0) s0 = ~s0;
                if ($urandom_range(0, 4 + e * 8) == 0) s1 = ~s1;
                req = {$urandom_range(0, 3 + e * 10) == 0, s1, s0};
                if (e == 3 && c == 250) reset_check("async_random");
            end
        end
        req = 3'b000;
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
